id_stage_param: RTL and testbench

ID_STAGE_PARAM -- requirements
Module: id_stage_param

---
 rtl/id_stage_param_if.sv | 10 +
 rtl/id_stage_param.sv | 224 ++++++++++++++++++++++
 tb/tb_id_stage_param.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_param_if.sv
// Observation port for the decode stage: halt FSM state, advance strobe and
// the unregistered branch decision.
interface id_stage_param_if;
  logic halted;
  logic adv;
  logic branch_take;

  modport master (output halted, output adv, output branch_take);
  modport slave  (input halted, input adv, input branch_take);
endinterface

// File: rtl/id_stage_param.sv
// Instruction decode stage: register file with write-back bypass, control decode,
// early branch resolution and a sticky halt FSM feeding the ID/EX register.
module id_stage_param #(
  parameter int LENGTH_INSTRUCTION = 32,
  parameter int CANT_REGISTROS = 32,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BITS_ADDR = 11,
  parameter logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF,
  parameter int BRANCH_IN_ID = 1,
  localparam int RB = $clog2(CANT_REGISTROS)
) (
  input  logic                           i_clock,
  input  logic                           i_soft_reset,
  input  logic [LENGTH_INSTRUCTION-1:0]  i_instruction,
  input  logic [CANT_BITS_ADDR-1:0]      i_out_adder_pc,
  input  logic                           i_control_write_reg,
  input  logic [RB-1:0]                  i_reg_write,
  input  logic [CANT_BITS_REGISTROS-1:0] i_data_write,
  input  logic                           i_enable_pipeline,
  input  logic                           i_enable_etapa,
  input  logic                           i_bit_burbuja_hazard,
  input  logic [RB-1:0]                  i_reg_read_from_debug_unit,
  output logic [CANT_BITS_REGISTROS-1:0] o_data_A,
  output logic [CANT_BITS_REGISTROS-1:0] o_data_B,
  output logic [CANT_BITS_REGISTROS-1:0] o_extension_signo_constante,
  output logic [RB-1:0]                  o_reg_rs,
  output logic [RB-1:0]                  o_reg_rt,
  output logic [RB-1:0]                  o_reg_rd,
  output logic [RB-1:0]                  o_reg_rs_to_hazard,
  output logic [RB-1:0]                  o_reg_rt_to_hazard,
  output logic                           o_RegDst,
  output logic                           o_RegWrite,
  output logic                           o_ALUSrc,
  output logic                           o_MemRead,
  output logic                           o_MemWrite,
  output logic                           o_MemtoReg,
  output logic [3:0]                     o_ALUCtrl,
  output logic [CANT_BITS_ADDR-1:0]      o_out_adder_pc,
  output logic [CANT_BITS_ADDR-1:0]      o_branch_dir,
  output logic                           o_branch_control,
  output logic                           o_halt_detected,
  output logic [CANT_BITS_REGISTROS-1:0] o_reg_data_to_debug_unit,
  id_stage_param_if.master               o_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t r_state, w_state_next;

  logic [CANT_BITS_REGISTROS-1:0] r_regs [CANT_REGISTROS];

  logic                           w_halted, w_adv, w_is_halt, w_wb_en;
  logic [5:0]                     w_opcode, w_funct;
  logic [RB-1:0]                  w_rs, w_rt, w_rd;
  logic [CANT_BITS_REGISTROS-1:0] w_data_a, w_data_b, w_imm_ext;
  // {RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, ALUCtrl[3:0]}
  logic [9:0]                     w_dec_ctrl;
  logic                           w_is_j, w_is_jr, w_is_beq, w_is_bne;
  logic                           w_branch_take;
  logic [CANT_BITS_ADDR-1:0]      w_branch_target, w_branch_dir;

  logic [CANT_BITS_REGISTROS-1:0] r_data_a, r_data_b, r_imm_ext;
  logic [RB-1:0]                  r_rs, r_rt, r_rd;
  logic [9:0]                     r_ctrl;
  logic [CANT_BITS_ADDR-1:0]      r_pc;

  assign w_halted  = (r_state == ST_HALTED);
  assign w_adv     = i_enable_pipeline & i_enable_etapa & ~w_halted;
  assign w_is_halt = (i_instruction == HALT_INSTRUCTION);
  assign w_wb_en   = i_control_write_reg & (i_reg_write != '0);

  assign w_opcode  = i_instruction[31:26];
  assign w_funct   = i_instruction[5:0];
  assign w_rs      = i_instruction[21 +: RB];
  assign w_rt      = i_instruction[16 +: RB];
  assign w_rd      = i_instruction[11 +: RB];
  assign w_imm_ext = {{(CANT_BITS_REGISTROS-16){i_instruction[15]}}, i_instruction[15:0]};

  // Write-back data is forwarded so a same-cycle write is visible to this read.
  assign w_data_a = (w_rs == '0) ? '0 :
                    (w_wb_en && (i_reg_write == w_rs)) ? i_data_write : r_regs[w_rs];
  assign w_data_b = (w_rt == '0) ? '0 :
                    (w_wb_en && (i_reg_write == w_rt)) ? i_data_write : r_regs[w_rt];
  assign o_reg_data_to_debug_unit =
    (i_reg_read_from_debug_unit == '0) ? '0 :
    (w_wb_en && (i_reg_write == i_reg_read_from_debug_unit)) ? i_data_write :
    r_regs[i_reg_read_from_debug_unit];

  assign o_reg_rs_to_hazard = w_rs;
  assign o_reg_rt_to_hazard = w_rt;

  always_comb begin
    w_dec_ctrl = '0;
    w_is_j     = 1'b0;
    w_is_jr    = 1'b0;
    w_is_beq   = 1'b0;
    w_is_bne   = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU: w_dec_ctrl = {6'b110000, 4'd0};
          FN_SUBU: w_dec_ctrl = {6'b110000, 4'd1};
          FN_AND:  w_dec_ctrl = {6'b110000, 4'd2};
          FN_OR:   w_dec_ctrl = {6'b110000, 4'd3};
          FN_SLT:  w_dec_ctrl = {6'b110000, 4'd4};
          FN_SLLV: w_dec_ctrl = {6'b110000, 4'd5};
          FN_JR:   w_is_jr    = 1'b1;
          default: w_dec_ctrl = '0;
        endcase
      end
      OP_ADDI: w_dec_ctrl = {6'b011000, 4'd0};
      OP_LW:   w_dec_ctrl = {6'b011101, 4'd0};
      OP_SW:   w_dec_ctrl = {6'b001010, 4'd0};
      OP_BEQ:  w_is_beq   = 1'b1;
      OP_BNE:  w_is_bne   = 1'b1;
      OP_J:    w_is_j     = 1'b1;
      default: w_dec_ctrl = '0;
    endcase
  end

  always_comb begin
    w_branch_target = i_out_adder_pc + i_instruction[CANT_BITS_ADDR-1:0];
    if (w_is_j)  w_branch_target = i_instruction[CANT_BITS_ADDR-1:0];
    if (w_is_jr) w_branch_target = w_data_a[CANT_BITS_ADDR-1:0];
  end

  assign w_branch_take = w_adv & ~i_bit_burbuja_hazard &
                         (w_is_j | w_is_jr |
                          (w_is_beq & (w_data_a == w_data_b)) |
                          (w_is_bne & (w_data_a != w_data_b)));
  assign w_branch_dir  = w_branch_take ? w_branch_target : '0;

  always_comb begin
    w_state_next = r_state;
    if ((r_state == ST_RUN) && w_adv && w_is_halt) w_state_next = ST_HALTED;
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) r_state <= ST_RUN;
    else               r_state <= w_state_next;
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      for (int i = 0; i < CANT_REGISTROS; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[i_reg_write] <= i_data_write;
    end
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      r_data_a  <= '0;
      r_data_b  <= '0;
      r_imm_ext <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
      r_pc      <= '0;
    end else if (w_adv) begin
      r_data_a  <= w_data_a;
      r_data_b  <= w_data_b;
      r_imm_ext <= w_imm_ext;
      r_rs      <= w_rs;
      r_rt      <= w_rt;
      r_rd      <= w_rd;
      r_ctrl    <= (i_bit_burbuja_hazard || w_is_halt) ? '0 : w_dec_ctrl;
      r_pc      <= i_out_adder_pc;
    end
  end

  assign o_data_A                    = r_data_a;
  assign o_data_B                    = r_data_b;
  assign o_extension_signo_constante = r_imm_ext;
  assign o_reg_rs                    = r_rs;
  assign o_reg_rt                    = r_rt;
  assign o_reg_rd                    = r_rd;
  assign {o_RegDst, o_RegWrite, o_ALUSrc, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUCtrl} = r_ctrl;
  assign o_out_adder_pc              = r_pc;
  assign o_halt_detected             = w_halted;

  generate
    if (BRANCH_IN_ID != 0) begin : g_branch_comb
      assign o_branch_control = w_branch_take;
      assign o_branch_dir     = w_branch_dir;
    end else begin : g_branch_reg
      // Sampled every edge, so the pulse clears itself when nothing is taken.
      logic                      r_branch_control;
      logic [CANT_BITS_ADDR-1:0] r_branch_dir;
      always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
          r_branch_control <= 1'b0;
          r_branch_dir     <= '0;
        end else begin
          r_branch_control <= w_branch_take;
          r_branch_dir     <= w_branch_dir;
        end
      end
      assign o_branch_control = r_branch_control;
      assign o_branch_dir     = r_branch_dir;
    end
  endgenerate

  assign o_dbg.halted      = w_halted;
  assign o_dbg.adv         = w_adv;
  assign o_dbg.branch_take = w_branch_take;

endmodule

// File: tb/tb_id_stage_param.sv
// Bench for id_stage_param: a combinational-branch and a registered-branch instance
// share stimulus and are checked against an instruction-level model every cycle.
module tb_id_stage_param;
  localparam int W = 32;
  localparam int A = 11;
  localparam int RB = 5;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]   instr;
  logic [A-1:0]  pc_in;
  logic          wen;
  logic [RB-1:0] waddr;
  logic [W-1:0]  wdata;
  logic          en_pipe, en_etapa, bubble;
  logic [RB-1:0] dbg_addr;

  logic [W-1:0]  a0, b0, ext0, dbgd0, a1, b1, ext1, dbgd1;
  logic [RB-1:0] rs0, rt0, rd0, hrs0, hrt0, rs1, rt1, rd1, hrs1, hrt1;
  logic          regdst0, regwrite0, alusrc0, memread0, memwrite0, memtoreg0;
  logic          regdst1, regwrite1, alusrc1, memread1, memwrite1, memtoreg1;
  logic [3:0]    aluctrl0, aluctrl1;
  logic [A-1:0]  pc0, bdir0, pc1, bdir1;
  logic          bctl0, halt0, bctl1, halt1;

  id_stage_param_if dbg0 ();
  id_stage_param_if dbg1 ();

  id_stage_param #(.BRANCH_IN_ID(1)) u_dut0 (
    .i_clock(clk), .i_soft_reset(rst_n), .i_instruction(instr), .i_out_adder_pc(pc_in),
    .i_control_write_reg(wen), .i_reg_write(waddr), .i_data_write(wdata),
    .i_enable_pipeline(en_pipe), .i_enable_etapa(en_etapa), .i_bit_burbuja_hazard(bubble),
    .i_reg_read_from_debug_unit(dbg_addr),
    .o_data_A(a0), .o_data_B(b0), .o_extension_signo_constante(ext0),
    .o_reg_rs(rs0), .o_reg_rt(rt0), .o_reg_rd(rd0),
    .o_reg_rs_to_hazard(hrs0), .o_reg_rt_to_hazard(hrt0),
    .o_RegDst(regdst0), .o_RegWrite(regwrite0), .o_ALUSrc(alusrc0), .o_MemRead(memread0),
    .o_MemWrite(memwrite0), .o_MemtoReg(memtoreg0), .o_ALUCtrl(aluctrl0),
    .o_out_adder_pc(pc0), .o_branch_dir(bdir0), .o_branch_control(bctl0),
    .o_halt_detected(halt0), .o_reg_data_to_debug_unit(dbgd0), .o_dbg(dbg0)
  );

  id_stage_param #(.BRANCH_IN_ID(0)) u_dut1 (
    .i_clock(clk), .i_soft_reset(rst_n), .i_instruction(instr), .i_out_adder_pc(pc_in),
    .i_control_write_reg(wen), .i_reg_write(waddr), .i_data_write(wdata),
    .i_enable_pipeline(en_pipe), .i_enable_etapa(en_etapa), .i_bit_burbuja_hazard(bubble),
    .i_reg_read_from_debug_unit(dbg_addr),
    .o_data_A(a1), .o_data_B(b1), .o_extension_signo_constante(ext1),
    .o_reg_rs(rs1), .o_reg_rt(rt1), .o_reg_rd(rd1),
    .o_reg_rs_to_hazard(hrs1), .o_reg_rt_to_hazard(hrt1),
    .o_RegDst(regdst1), .o_RegWrite(regwrite1), .o_ALUSrc(alusrc1), .o_MemRead(memread1),
    .o_MemWrite(memwrite1), .o_MemtoReg(memtoreg1), .o_ALUCtrl(aluctrl1),
    .o_out_adder_pc(pc1), .o_branch_dir(bdir1), .o_branch_control(bctl1),
    .o_halt_detected(halt1), .o_reg_data_to_debug_unit(dbgd1), .o_dbg(dbg1)
  );

  // Instruction-level model
  typedef enum {M_NOP, M_ADDU, M_SUBU, M_AND, M_OR, M_SLT, M_SLLV,
                M_ADDI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JR} mn_t;
  typedef struct packed {
    logic regdst, regwrite, alusrc, memread, memwrite, memtoreg;
    logic [3:0] alu;
  } ctl_t;
  typedef struct packed {
    logic [W-1:0] a, b, ext;
    logic [RB-1:0] rs, rt, rd;
    ctl_t ctl;
    logic [A-1:0] pc;
  } idex_t;

  logic [W-1:0] m_regs [32];
  bit           m_halted;
  idex_t        m_idex;
  logic         m_bctl1;
  logic [A-1:0] m_bdir1;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mn_t mnem(input logic [31:0] ins);
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h21: return M_ADDU;
        6'h23: return M_SUBU;
        6'h24: return M_AND;
        6'h25: return M_OR;
        6'h2A: return M_SLT;
        6'h04: return M_SLLV;
        6'h08: return M_JR;
        default: return M_NOP;
      endcase
    end
    case (ins[31:26])
      6'h08: return M_ADDI;
      6'h23: return M_LW;
      6'h2B: return M_SW;
      6'h04: return M_BEQ;
      6'h05: return M_BNE;
      6'h02: return M_J;
      default: return M_NOP;
    endcase
  endfunction

  function automatic ctl_t ctl_of(input mn_t m);
    ctl_t c;
    c = '0;
    case (m)
      M_ADDU, M_SUBU, M_AND, M_OR, M_SLT, M_SLLV: begin c.regdst = 1; c.regwrite = 1; end
      M_ADDI: begin c.regwrite = 1; c.alusrc = 1; end
      M_LW:   begin c.regwrite = 1; c.alusrc = 1; c.memread = 1; c.memtoreg = 1; end
      M_SW:   begin c.alusrc = 1; c.memwrite = 1; end
      default: ;
    endcase
    case (m)
      M_SUBU: c.alu = 4'd1;
      M_AND:  c.alu = 4'd2;
      M_OR:   c.alu = 4'd3;
      M_SLT:  c.alu = 4'd4;
      M_SLLV: c.alu = 4'd5;
      default: c.alu = 4'd0;
    endcase
    return c;
  endfunction

  function automatic logic [W-1:0] mread(input logic [RB-1:0] ad);
    if (ad == 0) return '0;
    if (wen && waddr == ad) return wdata;
    return m_regs[ad];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fns [7];
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] r;
    int k;
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h04, 6'h08};
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    k   = $urandom_range(0, 14);
    case (k)
      7:  r = {6'h08, rs, rt, imm};
      8:  r = {6'h23, rs, rt, imm};
      9:  r = {6'h2B, rs, rt, imm};
      10: r = {6'h04, rs, rt, imm};
      11: r = {6'h05, rs, rt, imm};
      12: r = {6'h02, 26'($urandom)};
      13: r = 32'h0;
      14: begin r = $urandom; if (r == HALT) r = 32'h0; end
      default: r = {6'h00, rs, rt, rd, 5'd0, fns[k]};
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_halted = 0;
    m_idex   = '0;
    m_bctl1  = 0;
    m_bdir1  = '0;
  endtask

  // Driver tasks
  task automatic set_in(input logic [31:0] ins, input logic [A-1:0] pc, input logic we,
                        input logic [RB-1:0] wa, input logic [W-1:0] wd,
                        input logic ep, input logic ee, input logic bub);
    instr = ins; pc_in = pc; wen = we; waddr = wa; wdata = wd;
    en_pipe = ep; en_etapa = ee; bubble = bub;
  endtask

  // One clock: check combinational outputs before the edge, registered ones after.
  task automatic step();
    logic adv, take;
    mn_t m;
    logic [W-1:0] ra, rb;
    logic [A-1:0] tgt, dir;
    #1;
    adv  = en_pipe && en_etapa && !m_halted;
    m    = mnem(instr);
    ra   = mread(instr[25:21]);
    rb   = mread(instr[20:16]);
    take = adv && !bubble && (m == M_J || m == M_JR ||
                              (m == M_BEQ && ra == rb) || (m == M_BNE && ra != rb));
    case (m)
      M_J:     tgt = instr[A-1:0];
      M_JR:    tgt = ra[A-1:0];
      default: tgt = pc_in + instr[A-1:0];
    endcase
    dir = take ? tgt : '0;
    chk("haz_rs", hrs0, instr[25:21]);
    chk("haz_rt", hrt0, instr[20:16]);
    chk("dbg_data", dbgd0, mread(dbg_addr));
    chk("br_ctl_comb", bctl0, take);
    chk("br_dir_comb", bdir0, dir);
    chk("br_reg_hold", {bctl1, bdir1}, {m_bctl1, m_bdir1});
    chk("dbg_if_halted", dbg0.halted, m_halted);
    @(posedge clk);
    if (wen && waddr != 0) m_regs[waddr] = wdata;
    if (adv) begin
      m_idex.a   = ra;
      m_idex.b   = rb;
      m_idex.ext = {{16{instr[15]}}, instr[15:0]};
      m_idex.rs  = instr[25:21];
      m_idex.rt  = instr[20:16];
      m_idex.rd  = instr[15:11];
      m_idex.pc  = pc_in;
      m_idex.ctl = (bubble || instr == HALT) ? '0 : ctl_of(m);
      if (instr == HALT) m_halted = 1;
    end
    m_bctl1 = take;
    m_bdir1 = dir;
    #1;
    chk("data_A", a0, m_idex.a);
    chk("data_B", b0, m_idex.b);
    chk("imm_ext", ext0, m_idex.ext);
    chk("fields", {rs0, rt0, rd0}, {m_idex.rs, m_idex.rt, m_idex.rd});
    chk("ctrl", {regdst0, regwrite0, alusrc0, memread0, memwrite0, memtoreg0, aluctrl0}, m_idex.ctl);
    chk("pc_out", pc0, m_idex.pc);
    chk("idex_inst1", {a1, b1, ext1, rs1, rt1, rd1, regdst1, regwrite1, alusrc1, memread1,
                       memwrite1, memtoreg1, aluctrl1, pc1}, m_idex);
    chk("br_reg", {bctl1, bdir1}, {m_bctl1, m_bdir1});
    chk("halt", {halt0, halt1}, {m_halted, m_halted});
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [A-1:0] pc, input logic we,
                       input logic [RB-1:0] wa, input logic [W-1:0] wd,
                       input logic ep, input logic ee, input logic bub);
    set_in(ins, pc, we, wa, wd, ep, ee, bub);
    step();
  endtask

  task automatic rand_step();
    instr    = rand_instr();
    pc_in    = A'($urandom);
    wen      = 1'($urandom_range(0, 1));
    waddr    = ($urandom_range(0, 3) == 0) ? RB'($urandom_range(0, 31)) : RB'($urandom_range(0, 7));
    wdata    = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
    en_pipe  = ($urandom_range(0, 9) != 0);
    en_etapa = ($urandom_range(0, 7) != 0);
    bubble   = ($urandom_range(0, 9) == 0);
    dbg_addr = RB'($urandom_range(0, 7));
    step();
  endtask

  // Called just after a falling edge; asserts reset asynchronously away from any edge.
  task automatic do_reset();
    set_in(32'h0, '0, 0, '0, '0, 0, 0, 0);
    dbg_addr = 5'd1;
    rst_n = 1'b0;
    #2;
    chk("rst_halt", {halt0, halt1}, 2'b00);
    chk("rst_idex0", {a0, b0, ext0, rs0, rt0, rd0, regdst0, regwrite0, alusrc0, memread0,
                      memwrite0, memtoreg0, aluctrl0, pc0}, 0);
    chk("rst_branch", {bctl0, bdir0, bctl1, bdir1}, 0);
    chk("rst_regfile", dbgd0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(32'h0, '0, 0, '0, '0, 0, 0, 0);
    dbg_addr = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      rand_step();
    end

    // Directed: ADDU after two write-backs
    dbg_addr = 5'd3;
    drive(32'h0, '0, 1, 5'd1, 32'd4, 1, 1, 0);
    drive(32'h0, '0, 1, 5'd2, 32'd3, 1, 1, 0);
    drive(32'h00221821, 11'd7, 0, '0, '0, 1, 1, 0);
    chk("lit_addu_A", a0, 32'd4);
    chk("lit_addu_B", b0, 32'd3);
    chk("lit_addu_rd", rd0, 5'd3);
    chk("lit_addu_ctl", {regwrite0, aluctrl0}, {1'b1, 4'd0});

    // JR R20 with R20=9 written in the same cycle
    set_in(32'h02800008, '0, 1, 5'd20, 32'd9, 1, 1, 0);
    #1;
    chk("lit_jr_comb", {bctl0, bdir0}, {1'b1, 11'd9});
    step();
    chk("lit_jr_reg", {bctl1, bdir1}, {1'b1, 11'd9});
    drive(32'h0, '0, 0, '0, '0, 1, 1, 0);
    chk("lit_jr_reg_clear", {bctl1, bdir1}, 0);

    // BEQ R20,R3,9 with pc+1=5
    drive(32'h0, '0, 1, 5'd3, 32'd9, 1, 1, 0);
    set_in(32'h12830009, 11'd5, 0, '0, '0, 1, 1, 0);
    #1;
    chk("lit_beq_taken", {bctl0, bdir0}, {1'b1, 11'd14});
    step();
    drive(32'h0, '0, 1, 5'd3, 32'd1, 1, 1, 0);
    set_in(32'h12830009, 11'd5, 0, '0, '0, 1, 1, 0);
    #1;
    chk("lit_beq_not_taken", {bctl0, bdir0}, 0);
    step();

    // Stage-enable low holds ID/EX
    drive(32'h00221821, 11'd7, 0, '0, '0, 1, 1, 0);
    repeat (3) drive(rand_instr(), A'($urandom), 0, '0, '0, 1, 0, 0);
    chk("lit_hold", {a0, rd0, regwrite0, pc0}, {32'd4, 5'd3, 1'b1, 11'd7});

    // Bubble on LW
    drive(32'h8C220004, 11'd2, 0, '0, '0, 1, 1, 1);
    chk("lit_bubble_lw", {memread0, memtoreg0, rt0, ext0}, {1'b0, 1'b0, 5'd2, 32'd4});
    drive(32'h8C220004, 11'd2, 0, '0, '0, 1, 1, 0);
    chk("lit_lw", {memread0, memtoreg0, alusrc0, regwrite0, regdst0}, 5'b11110);

    // Halt, then writes and debug reads continue while frozen
    drive(HALT, 11'd3, 0, '0, '0, 1, 1, 0);
    chk("lit_halt", {halt0, regwrite0, memread0}, {1'b1, 1'b0, 1'b0});
    drive(32'h00221821, 11'd4, 1, 5'd5, 32'h55, 1, 1, 0);
    chk("lit_halt_frozen", {halt0, regwrite0, pc0}, {1'b1, 1'b0, 11'd3});
    dbg_addr = 5'd5;
    set_in(32'h08000010, 11'd4, 0, '0, '0, 1, 1, 0);
    #1;
    chk("lit_halt_dbg", {dbgd0, bctl0}, {32'h55, 1'b0});
    step();
    for (int i = 0; i < 10; i++) rand_step();

    do_reset();
    chk("lit_after_reset", {halt0, dbg0.halted}, 2'b00);
    for (int i = 0; i < 60; i++) rand_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
